// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and round-robin search helper for mux_select_arbiter
package mux_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Upper bound on requesters the search helper handles; the select index
  // type is sized for it and narrowed by each user to $clog2(NUM_REQ).
  localparam int MAX_REQ   = 16;
  localparam int SEL_MAX_W = 4;

  typedef logic [SEL_MAX_W-1:0] sel_idx_t;

  // First set bit at or after ptr, wrapping modulo n. Returns 0 when no bit is set.
  function automatic sel_idx_t next_req(input logic [MAX_REQ-1:0] req,
                                        input sel_idx_t          ptr,
                                        input int                n);
    sel_idx_t idx;
    logic     hit;
    int       k;
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= n) k = k - n;
      if (i < n && !hit && req[k[SEL_MAX_W-1:0]]) begin
        idx = k[SEL_MAX_W-1:0];
        hit = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick of the first request at or after ptr
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       found_o
);

  localparam int SEL_W = $clog2(NUM_REQ);

  logic [MAX_REQ-1:0] req_pad;
  sel_idx_t           pick;

  // Widen the request vector to the helper's width and narrow the result back.
  always_comb begin
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = req_i;
    pick                   = next_req(req_pad, sel_idx_t'(ptr_i), NUM_REQ);
    idx_o                  = pick[SEL_W-1:0];
    found_o                = |req_i;
  end

endmodule

// File: rtl/mux_select_arbiter.sv
// rtl/mux_select_arbiter.sv - round-robin owner of a shared mux select with a registered output stage
module mux_select_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*WIDTH-1:0]   data_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] select_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       busy_o
);

  localparam int SEL_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [SEL_W-1:0]  LAST_IDX  = SEL_W'(NUM_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  select_q, select_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q, data_d;

  logic [SEL_W-1:0]  pick_idx;
  logic              pick_found;
  logic              open;
  logic              req_sel;
  logic              accept;
  logic [WIDTH-1:0]  data_sel;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Beat accept: the owner's beat is taken when it requests and the output slot is free or draining.
  always_comb begin
    open     = !valid_q || ready_i;
    req_sel  = req_i[select_q];
    data_sel = data_i[select_q*WIDTH +: WIDTH];
    accept   = (state_q == GRANT) && req_sel && open;
    gnt_o    = '0;
    if (accept) gnt_o[select_q] = 1'b1;
  end

  // Next state: ownership FSM, hold counter, output register with accept/drain overlap.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    select_d = select_q;
    hold_d   = hold_q;
    valid_d  = valid_q;
    data_d   = data_q;

    if (valid_q && ready_i) valid_d = 1'b0;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = data_sel;
      hold_d  = hold_q + HOLD_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          select_d = pick_idx;
          hold_d   = '0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        // Release only while the slot is open, so backpressure never moves ownership.
        if ((accept && hold_q == HOLD_LAST) || (open && !req_sel)) begin
          state_d = IDLE;
          ptr_d   = (select_q == LAST_IDX) ? '0 : select_q + SEL_W'(1);
          hold_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, cleared asynchronously; a held beat is discarded on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      select_q <= '0;
      hold_q   <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      select_q <= select_d;
      hold_q   <= hold_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign select_o = select_q;
  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign busy_o   = (state_q == GRANT);

endmodule

// File: tb/tb_mux_select_arbiter.sv
// tb/tb_mux_select_arbiter.sv - directed self-checking bench for mux_select_arbiter
module tb_mux_select_arbiter;

  logic clk;
  logic rst_n;

  // Instance A: 2 requesters, 4-bit data, MAX_HOLD=4
  logic [1:0] req_a;
  logic [7:0] data_a;
  logic       ready_a;
  logic [1:0] gnt_a;
  logic       select_a;
  logic       valid_a;
  logic [3:0] dout_a;
  logic       busy_a;

  // Instance B: 3 requesters, 1-bit data, MAX_HOLD=1
  logic [2:0] req_b;
  logic [2:0] data_b;
  logic       ready_b;
  logic [2:0] gnt_b;
  logic [1:0] select_b;
  logic       valid_b;
  logic       dout_b;
  logic       busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  mux_select_arbiter #(.NUM_REQ(2), .WIDTH(4), .MAX_HOLD(4)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .data_i(data_a), .gnt_o(gnt_a),
    .select_o(select_a), .valid_o(valid_a), .ready_i(ready_a), .data_o(dout_a), .busy_o(busy_a)
  );

  mux_select_arbiter #(.NUM_REQ(3), .WIDTH(1), .MAX_HOLD(1)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .data_i(data_b), .gnt_o(gnt_b),
    .select_o(select_b), .valid_o(valid_b), .ready_i(ready_b), .data_o(dout_b), .busy_o(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change in the low phase; outputs are sampled 1 time unit later.
  task automatic drive_a(input logic [1:0] r, input logic [7:0] d, input logic rdy);
    @(negedge clk);
    req_a = r; data_a = d; ready_a = rdy;
    #1;
  endtask

  task automatic drive_b(input logic [2:0] r, input logic [2:0] d, input logic rdy);
    @(negedge clk);
    req_b = r; data_b = d; ready_b = rdy;
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0; req_a = '0; req_b = '0; ready_a = 1'b1; ready_b = 1'b1;
    #1;
    chk({tag, "_gnt"},    {30'd0, gnt_a},   32'd0);
    chk({tag, "_sel"},    {31'd0, select_a}, 32'd0);
    chk({tag, "_valid"},  {31'd0, valid_a}, 32'd0);
    chk({tag, "_data"},   {28'd0, dout_a},  32'd0);
    chk({tag, "_busy"},   {31'd0, busy_a},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({tag, "_gnt_rel"}, {30'd0, gnt_a}, 32'd0);
  endtask

  logic [1:0] solo_gnt   [1:6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01};
  logic       solo_valid [1:6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0] cont_gnt   [0:11] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                                    2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
  logic       cont_sel   [0:11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [2:0] b_gnt      [1:7] = '{3'b001, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b100};
  logic [1:0] b_sel      [1:7] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd2};

  initial begin
    rst_n = 1'b0;
    req_a = '0; data_a = '0; ready_a = 1'b1;
    req_b = '0; data_b = '0; ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("por_gnt",   {30'd0, gnt_a},  32'd0);
    chk("por_valid", {31'd0, valid_a}, 32'd0);
    chk("por_busy",  {31'd0, busy_a}, 32'd0);

    // Reset release with a request already up: no grant this cycle, grant next.
    @(negedge clk);
    rst_n = 1'b1; req_a = 2'b01; data_a = 8'h00;
    #1;
    chk("rel_gnt0", {30'd0, gnt_a}, 32'd0);

    // Solo streaming: 4 beats, one IDLE bubble, re-grant to requester 0.
    for (int k = 1; k <= 6; k++) begin
      drive_a(2'b01, {4'h0, 4'(k)}, 1'b1);
      chk($sformatf("solo_gnt%0d", k),   {30'd0, gnt_a},  {30'd0, solo_gnt[k]});
      chk($sformatf("solo_busy%0d", k),  {31'd0, busy_a}, {31'd0, |solo_gnt[k]});
      chk($sformatf("solo_valid%0d", k), {31'd0, valid_a}, {31'd0, solo_valid[k]});
      if (k >= 2 && k <= 5) chk($sformatf("solo_data%0d", k), {28'd0, dout_a}, k - 1);
    end

    // Mid-beat reset: the beat accepted in the last cycle is in the register.
    drive_a(2'b01, 8'h07, 1'b0);
    chk("pre_rst_valid", {31'd0, valid_a}, 32'd1);
    do_reset("rst_mid");

    // Contention: 4 beats each, alternating owner with one bubble per rotation.
    for (int c = 0; c <= 11; c++) begin
      drive_a(2'b11, {4'(8 + c), 4'(c)}, 1'b1);
      chk($sformatf("cont_gnt%0d", c), {30'd0, gnt_a},    {30'd0, cont_gnt[c]});
      chk($sformatf("cont_sel%0d", c), {31'd0, select_a}, {31'd0, cont_sel[c]});
      if (c == 2) chk("cont_data2", {28'd0, dout_a}, 32'd1);
      if (c == 7) chk("cont_data7", {28'd0, dout_a}, 32'd14);
    end

    // Backpressure: 3 beats, then 5 stalled cycles with hold_cnt at 3.
    do_reset("rst_bp");
    for (int c = 0; c <= 3; c++) drive_a(2'b01, {4'h0, 4'(c)}, 1'b1);
    for (int c = 4; c <= 8; c++) begin
      drive_a(2'b01, {4'h0, 4'(c)}, 1'b0);
      chk($sformatf("bp_gnt%0d", c),   {30'd0, gnt_a},   32'd0);
      chk($sformatf("bp_valid%0d", c), {31'd0, valid_a}, 32'd1);
      chk($sformatf("bp_data%0d", c),  {28'd0, dout_a},  32'd3);
      chk($sformatf("bp_busy%0d", c),  {31'd0, busy_a},  32'd1);
    end
    drive_a(2'b01, 8'h09, 1'b1);
    chk("bp_accept_gnt", {30'd0, gnt_a}, 32'd1);
    drive_a(2'b01, 8'h0A, 1'b1);
    chk("bp_after_valid", {31'd0, valid_a}, 32'd1);
    chk("bp_after_data",  {28'd0, dout_a},  32'd9);
    chk("bp_after_busy",  {31'd0, busy_a},  32'd0);

    // Early drop after 2 beats: release moves ptr to 1, so 2'b11 picks requester 1.
    do_reset("rst_drop");
    drive_a(2'b01, 8'h00, 1'b1);
    drive_a(2'b01, 8'h01, 1'b1);
    chk("drop_gnt1", {30'd0, gnt_a}, 32'd1);
    drive_a(2'b01, 8'h02, 1'b1);
    chk("drop_gnt2", {30'd0, gnt_a}, 32'd1);
    drive_a(2'b00, 8'h03, 1'b1);
    chk("drop_gnt3",  {30'd0, gnt_a},  32'd0);
    chk("drop_busy3", {31'd0, busy_a}, 32'd1);
    drive_a(2'b11, 8'h54, 1'b1);
    chk("drop_idle_gnt", {30'd0, gnt_a},  32'd0);
    chk("drop_idle_busy", {31'd0, busy_a}, 32'd0);
    drive_a(2'b11, 8'h65, 1'b1);
    chk("drop_regnt",     {30'd0, gnt_a},    32'd2);
    chk("drop_regnt_sel", {31'd0, select_a}, 32'd1);

    // Three requesters, MAX_HOLD=1, requests on 0 and 2 only.
    do_reset("rst_b");
    drive_b(3'b101, 3'b001, 1'b1);
    chk("b_gnt0", {29'd0, gnt_b}, 32'd0);
    for (int c = 1; c <= 7; c++) begin
      drive_b(3'b101, 3'b001, 1'b1);
      chk($sformatf("b_gnt%0d", c), {29'd0, gnt_b},    {29'd0, b_gnt[c]});
      chk($sformatf("b_sel%0d", c), {30'd0, select_b}, {30'd0, b_sel[c]});
      chk($sformatf("b_sel_range%0d", c), {31'd0, (select_b == 2'd1) || (select_b == 2'd3)}, 32'd0);
      if (c == 2) chk("b_data2", {31'd0, dout_b}, 32'd1);
      if (c == 4) chk("b_data4", {31'd0, dout_b}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
